store_pack: RTL and testbench

Store-side packer and write buffer for the MEM stage: the narrowing counterpart of the immediate/load extenders. It takes a store (SB/SH/SW) with a 32-bit register value and byte address, and replicates the low byte/halfword across the word with a 4-bit byte enable. It checks alignment and address legality and raises AdES. Legal stores are queued in a small FIFO and drained to the bridge over a req/ack handshake.

---
 rtl/store_pack.sv | 167 ++++++++++++++++
 tb/tb_store_pack.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_pack.sv
// store_pack: MEM-stage store packer and in-order write buffer.
// Replicates the store byte/halfword across the 32-bit word, builds the byte
// enable, flags AdES for misaligned or illegal targets, and queues legal
// stores in a small FIFO that drains to the bridge one entry at a time.
//
// Handshake semantics (both sides):
//   upstream   : a store is accepted on a rising edge when st_valid=1,
//                st_op!=00, st_exc=0 and st_ready=1. st_ready depends only on
//                the buffer occupancy, never on bus_ack or on st_valid.
//   downstream : the head entry is offered while bus_req=1 and is consumed on
//                a rising edge when bus_req=1 and bus_ack=1. The head holds
//                steady until consumed; bus_ack with bus_req=0 has no effect.
module store_pack #(
   parameter int          DEPTH     = 2,
   parameter logic [31:0] DM_END    = 32'h0000_2FFF,
   parameter logic [31:0] TIM0_BASE = 32'h0000_7F00,
   parameter logic [31:0] TIM1_BASE = 32'h0000_7F10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        st_valid,
   input  logic [1:0]  st_op,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   output logic        st_ready,
   output logic        st_exc,
   output logic        bus_req,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_ack,
   output logic        empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [1:0] OP_NONE = 2'b00;
   localparam logic [1:0] OP_SB   = 2'b01;
   localparam logic [1:0] OP_SH   = 2'b10;
   localparam logic [1:0] OP_SW   = 2'b11;

   // Timer register windows are 12 bytes; offset 8 is the read-only COUNT.
   localparam logic [31:0] TIM_SPAN  = 32'd12;
   localparam logic [31:0] TIM_COUNT = 32'd8;

   // Packed request
   logic [31:0] pk_data;
   logic [3:0]  pk_be;

   // Address classification
   logic [31:0] t0_off;
   logic [31:0] t1_off;
   logic        in_dm;
   logic        in_t0;
   logic        in_t1;
   logic        in_tim;
   logic        to_count;
   logic        misaligned;
   logic        bad_target;

   // FIFO state
   logic [29:0] mem_waddr [DEPTH];
   logic [31:0] mem_data  [DEPTH];
   logic [3:0]  mem_be    [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          full;
   logic          push;
   logic          pop;

   // Replicate the low byte/halfword and derive the byte enable from the address.
   always_comb begin
      pk_data = '0;
      pk_be   = '0;
      case (st_op)
         OP_SB: begin
            pk_data = {4{st_data[7:0]}};
            pk_be   = 4'b0001 << st_addr[1:0];
         end
         OP_SH: begin
            pk_data = {2{st_data[15:0]}};
            pk_be   = st_addr[1] ? 4'b1100 : 4'b0011;
         end
         OP_SW: begin
            pk_data = st_data;
            pk_be   = 4'b1111;
         end
         default: begin
            pk_data = '0;
            pk_be   = '0;
         end
      endcase
   end

   // Classify the target address and decide whether the store raises AdES.
   always_comb begin
      t0_off     = st_addr - TIM0_BASE;
      t1_off     = st_addr - TIM1_BASE;
      in_dm      = (st_addr <= DM_END);
      in_t0      = (st_addr >= TIM0_BASE) && (t0_off < TIM_SPAN);
      in_t1      = (st_addr >= TIM1_BASE) && (t1_off < TIM_SPAN);
      in_tim     = in_t0 || in_t1;
      to_count   = (in_t0 && (t0_off == TIM_COUNT)) || (in_t1 && (t1_off == TIM_COUNT));
      misaligned = 1'b0;
      bad_target = 1'b0;
      case (st_op)
         OP_SB: begin
            misaligned = 1'b0;
            bad_target = in_tim || !in_dm;
         end
         OP_SH: begin
            misaligned = st_addr[0];
            bad_target = in_tim || !in_dm;
         end
         OP_SW: begin
            misaligned = (st_addr[1:0] != 2'b00);
            bad_target = (!in_dm && !in_tim) || to_count;
         end
         default: begin
            misaligned = 1'b0;
            bad_target = 1'b0;
         end
      endcase
      st_exc = st_valid && (st_op != OP_NONE) && (misaligned || bad_target);
   end

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign st_ready = !full;
   assign push     = !reset && st_valid && (st_op != OP_NONE) && !st_exc && st_ready;
   assign pop      = !reset && bus_req && bus_ack;

   // Head entry toward the bridge; outputs read as zero when nothing is queued.
   assign bus_req   = !empty;
   assign bus_addr  = empty ? 32'h0 : {mem_waddr[rd_ptr], 2'b00};
   assign bus_wdata = empty ? 32'h0 : mem_data[rd_ptr];
   assign bus_be    = empty ? 4'h0  : mem_be[rd_ptr];

   // Pointer and occupancy bookkeeping; reset discards everything buffered.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage; only the slot at the write pointer changes on a push.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_waddr[wr_ptr] <= st_addr[31:2];
         mem_data[wr_ptr]  <= pk_data;
         mem_be[wr_ptr]    <= pk_be;
      end
   end

endmodule

// File: tb/tb_store_pack.sv
// Directed testbench for store_pack (DEPTH=2).
module tb_store_pack;

   logic        clk;
   logic        reset;
   logic        st_valid;
   logic [1:0]  st_op;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        st_ready;
   logic        st_exc;
   logic        bus_req;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack;
   logic        empty;

   int n_tests;
   int n_fail;
   logic [31:0] exp_q[$];
   logic [31:0] exp_v;

   store_pack #(.DEPTH(2)) dut (
      .clk(clk), .reset(reset),
      .st_valid(st_valid), .st_op(st_op), .st_addr(st_addr), .st_data(st_data),
      .st_ready(st_ready), .st_exc(st_exc),
      .bus_req(bus_req), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
      .bus_ack(bus_ack), .empty(empty)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge, then settle 1ns so outputs are sampled off-edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic present(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
      st_valid = 1'b1;
      st_op    = op;
      st_addr  = addr;
      st_data  = data;
   endtask

   task automatic idle();
      st_valid = 1'b0;
      st_op    = 2'b00;
      st_addr  = 32'h0;
      st_data  = 32'h0;
   endtask

   // Exception-only probe: present, compare st_exc, withdraw before any edge.
   task automatic probe_exc(input string tag, input logic [1:0] op, input logic [31:0] addr,
                            input logic exp);
      present(op, addr, 32'hDEAD_BEEF);
      #1;
      check(tag, {31'h0, st_exc}, {31'h0, exp});
      idle();
      #1;
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      reset    = 1'b1;
      bus_ack  = 1'b0;
      idle();
      step();
      step();
      reset = 1'b0;
      #1;

      // Reset state
      check("rst_req",   {31'h0, bus_req},  32'h0);
      check("rst_empty", {31'h0, empty},    32'h1);
      check("rst_ready", {31'h0, st_ready}, 32'h1);
      check("rst_be",    {28'h0, bus_be},   32'h0);
      check("rst_addr",  bus_addr,          32'h0);
      check("rst_wdata", bus_wdata,         32'h0);

      // SB to byte 3 of word 0x10
      present(2'b01, 32'h0000_0013, 32'h1234_56AB);
      #1;
      check("sb_exc", {31'h0, st_exc}, 32'h0);
      check("sb_req_before", {31'h0, bus_req}, 32'h0);
      step();
      idle();
      check("sb_req",   {31'h0, bus_req}, 32'h1);
      check("sb_addr",  bus_addr,         32'h0000_0010);
      check("sb_wdata", bus_wdata,        32'hABAB_ABAB);
      check("sb_be",    {28'h0, bus_be},  32'h8);
      bus_ack = 1'b1;
      step();
      bus_ack = 1'b0;
      check("sb_pop_empty", {31'h0, empty}, 32'h1);

      // SH to upper half of word 0x4
      present(2'b10, 32'h0000_0006, 32'h0000_BEEF);
      step();
      idle();
      check("sh_addr",  bus_addr,        32'h0000_0004);
      check("sh_wdata", bus_wdata,       32'hBEEF_BEEF);
      check("sh_be",    {28'h0, bus_be}, 32'hC);
      bus_ack = 1'b1;
      step();
      bus_ack = 1'b0;

      // Misaligned SH: exception, nothing queued even across an edge
      present(2'b10, 32'h0000_0005, 32'h0000_1111);
      #1;
      check("sh_odd_exc", {31'h0, st_exc}, 32'h1);
      step();
      idle();
      check("sh_odd_empty", {31'h0, empty}, 32'h1);

      // Legality table
      probe_exc("sw_mis_exc",    2'b11, 32'h0000_0002, 1'b1);
      probe_exc("sw_cnt0_exc",   2'b11, 32'h0000_7F08, 1'b1);
      probe_exc("sb_tim0_exc",   2'b01, 32'h0000_7F00, 1'b1);
      probe_exc("sh_tim1_exc",   2'b10, 32'h0000_7F12, 1'b1);
      probe_exc("sw_dmend_exc",  2'b11, 32'h0000_3000, 1'b1);
      probe_exc("sw_cnt1_exc",   2'b11, 32'h0000_7F18, 1'b1);
      probe_exc("sw_pastt0_exc", 2'b11, 32'h0000_7F0C, 1'b1);
      probe_exc("sw_lastdm_ok",  2'b11, 32'h0000_2FFC, 1'b0);
      probe_exc("sb_lastdm_ok",  2'b01, 32'h0000_2FFF, 1'b0);
      probe_exc("sw_tim1_ok",    2'b11, 32'h0000_7F10, 1'b0);
      probe_exc("nop_bad_ok",    2'b00, 32'h0000_7F08, 1'b0);

      // SW into timer 1 window, offset 4
      present(2'b11, 32'h0000_7F14, 32'h0000_0005);
      #1;
      check("sw_t1_exc", {31'h0, st_exc}, 32'h0);
      step();
      idle();
      check("sw_t1_addr",  bus_addr,        32'h0000_7F14);
      check("sw_t1_wdata", bus_wdata,       32'h0000_0005);
      check("sw_t1_be",    {28'h0, bus_be}, 32'hF);
      bus_ack = 1'b1;
      step();
      bus_ack = 1'b0;
      check("sw_t1_empty", {31'h0, empty}, 32'h1);

      // Fill with ack held low; third push must be refused
      present(2'b11, 32'h0000_0100, 32'hAAAA_0001);
      step();
      present(2'b11, 32'h0000_0104, 32'hAAAA_0002);
      step();
      present(2'b11, 32'h0000_0108, 32'hAAAA_0003);
      #1;
      check("full_ready", {31'h0, st_ready}, 32'h0);
      step();
      idle();
      check("full_head_stable", bus_addr, 32'h0000_0100);
      bus_ack = 1'b1;
      #1;
      check("full_ack_ready_same", {31'h0, st_ready}, 32'h0);
      step();
      bus_ack = 1'b0;
      check("full_ack_ready_next", {31'h0, st_ready}, 32'h1);
      check("drain2_addr",  bus_addr,  32'h0000_0104);
      check("drain2_wdata", bus_wdata, 32'hAAAA_0002);
      bus_ack = 1'b1;
      step();
      bus_ack = 1'b0;
      check("drain_empty", {31'h0, empty}, 32'h1);

      // Streaming with ack high every cycle: one in, one out, depth stays 1
      bus_ack = 1'b1;
      for (int i = 0; i < 6; i++) begin
         exp_v = 32'h5000_0000 + 32'(i * 17);
         present(2'b11, 32'h0000_0200 + 32'(i * 4), exp_v);
         exp_q.push_back(exp_v);
         #1;
         if (i > 0) begin
            check("stream_req",   {31'h0, bus_req},  32'h1);
            check("stream_ready", {31'h0, st_ready}, 32'h1);
            check("stream_head",  bus_wdata, exp_q.pop_front());
         end else begin
            check("stream_first_req", {31'h0, bus_req}, 32'h0);
         end
         step();
      end
      idle();
      check("stream_last", bus_wdata, exp_q.pop_front());
      step();
      bus_ack = 1'b0;
      check("stream_empty", {31'h0, empty}, 32'h1);
      check("stream_q_used", 32'(exp_q.size()), 32'h0);

      // Reset with two entries pending discards them; no push during reset
      present(2'b11, 32'h0000_0300, 32'h0000_0031);
      step();
      present(2'b01, 32'h0000_0305, 32'h0000_0032);
      step();
      idle();
      check("prerst_req", {31'h0, bus_req}, 32'h1);
      reset = 1'b1;
      present(2'b10, 32'h0000_0001, 32'h0);
      #1;
      check("rst_exc_follows", {31'h0, st_exc}, 32'h1);
      present(2'b11, 32'h0000_0000, 32'h0000_0077);
      step();
      idle();
      reset = 1'b0;
      #1;
      check("rst2_req",   {31'h0, bus_req},  32'h0);
      check("rst2_empty", {31'h0, empty},    32'h1);
      check("rst2_be",    {28'h0, bus_be},   32'h0);
      check("rst2_ready", {31'h0, st_ready}, 32'h1);
      check("rst2_wdata", bus_wdata,         32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
